// File: rtl/wbrrarbiter.sv
// Two-master round-robin arbiter for pipelined Wishbone: whole-CYC grants,
// outstanding-request cap and an optional hung-slave abort timer.
//
// state   | meaning
// IDLE    | no owner, both masters stalled
// OWN_A   | master A owns the slave port
// OWN_B   | master B owns the slave port
// ABORT   | owner's cycle killed by timeout, waiting for its cyc to fall
module wbrrarbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LGMAXOUT = 5,
  parameter int TIMEOUT  = 0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_ack,
  output logic            o_a_stall,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_ack,
  output logic            o_b_stall,
  output logic            o_b_err,
  output logic [DW-1:0]   o_rdata,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_data,
  output logic [DW/8-1:0] o_sel,
  input  logic            i_ack,
  input  logic            i_stall,
  input  logic            i_err,
  input  logic [DW-1:0]   i_data,
  output logic [1:0]      o_owner
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OWN_A = 2'd1;
  localparam logic [1:0] S_OWN_B = 2'd2;
  localparam logic [1:0] S_ABORT = 2'd3;

  localparam logic [1:0] WHO_NONE = 2'd0;
  localparam logic [1:0] WHO_A    = 2'd1;
  localparam logic [1:0] WHO_B    = 2'd2;

  localparam logic [LGMAXOUT-1:0] CNT_ONE = 1;

  logic [1:0]          state, state_n;
  logic [1:0]          owner, owner_n;
  logic [1:0]          last, last_n;
  logic [LGMAXOUT-1:0] cnt;
  logic                full, resp, accept, own;
  logic                sel_a, own_cyc, own_stb, other_cyc;
  logic                timeout_hit;

  assign sel_a     = (owner == WHO_A);
  assign own       = (state == S_OWN_A) || (state == S_OWN_B);
  assign own_cyc   = sel_a ? i_a_cyc : i_b_cyc;
  assign own_stb   = sel_a ? i_a_stb : i_b_stb;
  assign other_cyc = sel_a ? i_b_cyc : i_a_cyc;
  assign full      = &cnt;
  assign resp      = i_ack || i_err;
  assign accept    = o_stb && !i_stall;

  always_comb begin
    o_cyc     = own && own_cyc;
    o_stb     = o_cyc && own_stb && !full;
    o_we      = sel_a ? i_a_we   : i_b_we;
    o_addr    = sel_a ? i_a_addr : i_b_addr;
    o_data    = sel_a ? i_a_data : i_b_data;
    o_sel     = sel_a ? i_a_sel  : i_b_sel;
    o_rdata   = i_data;
    o_owner   = owner;
    // acks are gated by the master's own cyc so a master that walked away
    // mid-burst never sees a late response
    o_a_stall = (state != S_OWN_A) || i_stall || full;
    o_b_stall = (state != S_OWN_B) || i_stall || full;
    o_a_ack   = (state == S_OWN_A) && i_a_cyc && i_ack;
    o_b_ack   = (state == S_OWN_B) && i_b_cyc && i_ack;
    o_a_err   = (state == S_OWN_A) && i_a_cyc && (i_err || timeout_hit);
    o_b_err   = (state == S_OWN_B) && i_b_cyc && (i_err || timeout_hit);
  end

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
      localparam logic [TW-1:0] TMR_ONE  = 1;
      logic [TW-1:0] tmr;

      // fires in the cycle the idle count would reach TIMEOUT
      assign timeout_hit = o_cyc && (cnt != '0) && !resp && (tmr == TMR_LAST);

      always_ff @(posedge i_clk) begin
        if (i_reset || !o_cyc || (cnt == '0) || resp)
          tmr <= '0;
        else if (!timeout_hit)
          tmr <= tmr + TMR_ONE;
      end
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    case (state)
      S_IDLE: begin
        if (i_a_cyc && (!i_b_cyc || (last == WHO_B))) begin
          state_n = S_OWN_A;
          owner_n = WHO_A;
        end else if (i_b_cyc) begin
          state_n = S_OWN_B;
          owner_n = WHO_B;
        end
      end
      default: begin
        if (!own_cyc) begin
          last_n = owner;
          if (other_cyc) begin
            state_n = sel_a ? S_OWN_B : S_OWN_A;
            owner_n = sel_a ? WHO_B : WHO_A;
          end else begin
            state_n = S_IDLE;
            owner_n = WHO_NONE;
          end
        end else if (own && timeout_hit) begin
          state_n = S_ABORT;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      owner <= WHO_NONE;
      last  <= WHO_B;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || !o_cyc)
      cnt <= '0;
    else if (accept && !resp)
      cnt <= cnt + CNT_ONE;
    else if (resp && !accept && (cnt != '0))
      cnt <= cnt - CNT_ONE;
  end

endmodule

// File: tb/tb_wbrrarbiter.sv
// Directed bench for wbrrarbiter built with a 2-bit outstanding counter
// (full at 3) and a 16-cycle timeout.
module tb_wbrrarbiter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_a_cyc, i_a_stb, i_a_we;
  logic [31:0] i_a_addr, i_a_data;
  logic [3:0]  i_a_sel;
  logic        o_a_ack, o_a_stall, o_a_err;
  logic        i_b_cyc, i_b_stb, i_b_we;
  logic [31:0] i_b_addr, i_b_data;
  logic [3:0]  i_b_sel;
  logic        o_b_ack, o_b_stall, o_b_err;
  logic [31:0] o_rdata;
  logic        o_cyc, o_stb, o_we;
  logic [31:0] o_addr, o_data;
  logic [3:0]  o_sel;
  logic        i_ack, i_stall, i_err;
  logic [31:0] i_data;
  logic [1:0]  o_owner;

  int n_chk = 0;
  int n_err = 0;
  int beats, acks;

  always #5 i_clk = ~i_clk;

  wbrrarbiter #(.AW(32), .DW(32), .LGMAXOUT(2), .TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we),
    .i_a_addr(i_a_addr), .i_a_data(i_a_data), .i_a_sel(i_a_sel),
    .o_a_ack(o_a_ack), .o_a_stall(o_a_stall), .o_a_err(o_a_err),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we),
    .i_b_addr(i_b_addr), .i_b_data(i_b_data), .i_b_sel(i_b_sel),
    .o_b_ack(o_b_ack), .o_b_stall(o_b_stall), .o_b_err(o_b_err),
    .o_rdata(o_rdata), .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we),
    .o_addr(o_addr), .o_data(o_data), .o_sel(o_sel),
    .i_ack(i_ack), .i_stall(i_stall), .i_err(i_err), .i_data(i_data),
    .o_owner(o_owner)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset = 1'b1;
    i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = '0; i_a_sel = '0;
    i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_addr = '0; i_b_data = '0; i_b_sel = '0;
    i_ack = 0; i_stall = 0; i_err = 0; i_data = '0;
    tick();
    tick();
    i_reset = 1'b0;
    #1;
    check("rst_owner", o_owner, 0);
    check("rst_cyc", o_cyc, 0);
    check("rst_stb", o_stb, 0);
    check("rst_a_stall", o_a_stall, 1);
    check("rst_b_stall", o_b_stall, 1);
    check("rst_acks", {o_a_ack, o_b_ack, o_a_err, o_b_err}, 0);

    // A alone: four pipelined writes, each acked one cycle later
    i_a_cyc = 1; i_a_stb = 1; i_a_we = 1; i_a_addr = 32'h100; i_a_data = 32'hA000; i_a_sel = 4'hF;
    #1;
    check("t1_req_stall", o_a_stall, 1);
    check("t1_req_cyc", o_cyc, 0);
    tick();
    beats = 0; acks = 0;
    for (int k = 0; k < 5; k++) begin
      i_a_stb = (k < 4); i_a_addr = 32'h100 + k * 4; i_a_data = 32'hA000 + k; i_ack = (k > 0);
      #1;
      if (k == 0) begin
        check("t1_grant_owner", o_owner, 1);
        check("t1_grant_cyc", o_cyc, 1);
        check("t1_addr", o_addr, 32'h100);
        check("t1_data", o_data, 32'hA000);
        check("t1_we", o_we, 1);
      end
      check("t1_b_stall", o_b_stall, 1);
      check("t1_b_ack", o_b_ack, 0);
      if (o_stb && !o_a_stall) beats++;
      if (o_a_ack) acks++;
      tick();
    end
    check("t1_beats", beats, 4);
    check("t1_acks", acks, 4);
    i_a_cyc = 0; i_a_stb = 0; i_ack = 0;
    #1;
    check("t1_drop_cyc", o_cyc, 0);
    tick();
    check("t1_idle_owner", o_owner, 0);

    // simultaneous requests and round-robin handoff
    i_reset = 1; tick(); i_reset = 0;
    i_a_cyc = 1; i_b_cyc = 1;
    #1;
    check("t2_tie_b_stall", o_b_stall, 1);
    tick();
    check("t2_tie_owner", o_owner, 1);
    check("t2_tie_b_stall_own", o_b_stall, 1);
    i_a_cyc = 0;
    #1;
    check("t2_handoff_gap", o_cyc, 0);
    tick();
    check("t2_handoff_owner", o_owner, 2);
    check("t2_handoff_cyc", o_cyc, 1);
    check("t2_b_stall", o_b_stall, 0);
    check("t2_a_stall", o_a_stall, 1);
    i_b_cyc = 0;
    #1;
    check("t2_b_drop_cyc", o_cyc, 0);
    tick();
    check("t2_idle", o_owner, 0);
    i_a_cyc = 1; i_b_cyc = 1;
    tick();
    check("t2_rr_a", o_owner, 1);
    i_a_cyc = 0; i_b_cyc = 0;
    tick();
    i_a_cyc = 1; i_b_cyc = 1;
    tick();
    check("t2_rr_b", o_owner, 2);
    i_a_cyc = 0; i_b_cyc = 0;
    tick();

    // slave never acks: pipeline fills at 3, one ack frees one slot
    i_a_cyc = 1; i_a_stb = 1; i_a_we = 1;
    tick();
    beats = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_stb && !o_a_stall) beats++;
      if (k >= 3) check("t3_full_stall", o_a_stall, 1);
      tick();
    end
    check("t3_beats", beats, 3);
    i_ack = 1;
    #1;
    check("t3_ack_full", o_a_ack, 1);
    check("t3_stb_full", o_stb, 0);
    tick();
    i_ack = 0;
    #1;
    check("t3_refill_stb", o_stb, 1);
    check("t3_refill_stall", o_a_stall, 0);
    tick();
    check("t3_refull_stall", o_a_stall, 1);
    i_a_stb = 0; i_ack = 1;
    #1;
    check("t3_ack2", o_a_ack, 1);
    tick();
    // two still outstanding: master walks away
    i_ack = 0; i_a_cyc = 0;
    #1;
    check("t5_drop_cyc", o_cyc, 0);
    tick();
    i_ack = 1;
    #1;
    check("t5_late_a_ack", o_a_ack, 0);
    check("t5_late_b_ack", o_b_ack, 0);
    tick();
    i_ack = 0;

    // single read, slave hangs: error on the 16th idle cycle, then abort
    i_a_cyc = 1; i_a_stb = 1; i_a_we = 0;
    tick();
    check("t4_stb", o_stb, 1);
    tick();
    i_a_stb = 0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      check($sformatf("t4_err_%0d", k), o_a_err, (k == 16));
      tick();
    end
    check("t4_abort_cyc", o_cyc, 0);
    check("t4_abort_owner", o_owner, 1);
    check("t4_abort_stall", o_a_stall, 1);
    i_ack = 1;
    #1;
    check("t4_abort_ack", o_a_ack, 0);
    check("t4_abort_err", o_a_err, 0);
    tick();
    i_ack = 0; i_a_cyc = 0;
    #1;
    check("t4_abort_hold", o_owner, 1);
    tick();
    check("t4_exit_owner", o_owner, 0);

    // B muxing, err passthrough, stall passthrough, reset mid-burst
    i_b_cyc = 1; i_b_stb = 1; i_b_we = 1; i_b_addr = 32'h2000; i_b_data = 32'hB0B0;
    i_b_sel = 4'h3; i_data = 32'hCAFE;
    tick();
    check("t6_owner", o_owner, 2);
    check("t6_addr", o_addr, 32'h2000);
    check("t6_data", o_data, 32'hB0B0);
    check("t6_sel", o_sel, 4'h3);
    check("t6_we", o_we, 1);
    check("t6_rdata", o_rdata, 32'hCAFE);
    check("t6_a_stall", o_a_stall, 1);
    i_err = 1;
    #1;
    check("t6_b_err", o_b_err, 1);
    check("t6_a_err", o_a_err, 0);
    tick();
    i_err = 0; i_stall = 1;
    #1;
    check("t6_stall_pass", o_b_stall, 1);
    check("t6_stall_stb", o_stb, 1);
    tick();
    i_stall = 0; i_reset = 1;
    tick();
    check("t6_rst_cyc", o_cyc, 0);
    check("t6_rst_owner", o_owner, 0);
    check("t6_rst_a_stall", o_a_stall, 1);
    check("t6_rst_b_stall", o_b_stall, 1);
    i_reset = 0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
